// File: rtl/prog_fetch_unit_if.sv
// Bus bundle for prog_fetch_unit: instruction output stream, branch request and program loader port.
// master = fetch unit side, slave = consumer/loader side.
interface prog_fetch_unit_if #(
  parameter int PC_W    = 3,
  parameter int INSTR_W = 8
);
  // Output stream: a word transfers on a clock edge where out_valid & out_ready.
  // out/out_valid never change while out_valid=1 and out_ready=0.
  // Branch: br_valid is held by the source until the cycle br_taken=1.
  logic [INSTR_W-1:0] out;
  logic               out_valid;
  logic               out_ready;
  logic               br_valid;
  logic               br_rel;
  logic [PC_W-1:0]    br_target;
  logic               br_taken;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_wdata;

  modport master (
    output out, out_valid, br_taken,
    input  out_ready, br_valid, br_rel, br_target, prog_we, prog_addr, prog_wdata
  );

  modport slave (
    input  out, out_valid, br_taken,
    output out_ready, br_valid, br_rel, br_target, prog_we, prog_addr, prog_wdata
  );
endinterface

// File: rtl/prog_fetch_unit.sv
// Program counter plus instruction store; issues one registered word per advance over valid/ready,
// with stall, absolute/relative branch, halt/restart and optional PC wrap.
module prog_fetch_unit #(
  parameter int PC_W     = 3,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0,
  parameter bit WRAP     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [1:0]      fsm_state,
  prog_fetch_unit_if.master bus
);

  localparam int DEPTH = 1 << PC_W;
  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [PC_W-1:0]    pc_r, pc_n;
  logic [INSTR_W-1:0] out_r, out_n;
  logic               valid_r, valid_n;
  logic               br_taken_c;
  logic               adv;
  logic [INSTR_W-1:0] mem [DEPTH];

  // Store is deliberately not reset; it is only writable while not running.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state != S_RUN)) begin
      mem[bus.prog_addr] <= bus.prog_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc_r    <= PC_INIT;
      out_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_n;
      pc_r    <= pc_n;
      out_r   <= out_n;
      valid_r <= valid_n;
    end
  end

  assign adv = (state == S_RUN) && !stall && !halt_req && (!valid_r || bus.out_ready);

  always_comb begin
    state_n    = state;
    pc_n       = pc_r;
    out_n      = out_r;
    valid_n    = valid_r;
    br_taken_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = PC_INIT;
        end
      end
      S_RUN: begin
        if (adv) begin
          if (bus.br_valid) begin
            // A taken branch costs one bubble: nothing is issued this edge.
            br_taken_c = 1'b1;
            valid_n    = 1'b0;
            pc_n       = bus.br_rel ? (pc_r + bus.br_target) : bus.br_target;
          end else begin
            out_n   = mem[pc_r];
            valid_n = 1'b1;
            if (!WRAP && (pc_r == PC_LAST)) begin
              state_n = S_HALT;
            end else begin
              pc_n = pc_r + PC_W'(1);
            end
          end
        end else begin
          if (valid_r && bus.out_ready) valid_n = 1'b0;
          if (halt_req) state_n = S_HALT;
        end
      end
      S_HALT: begin
        // Pending word drains on its own; start resumes from the held pc.
        if (valid_r && bus.out_ready) valid_n = 1'b0;
        if (start) state_n = S_RUN;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign pc            = pc_r;
  assign halted        = (state == S_HALT);
  assign fsm_state     = state;
  assign bus.out       = out_r;
  assign bus.out_valid = valid_r;
  assign bus.br_taken  = br_taken_c;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Directed bench for prog_fetch_unit: a wrapping and a non-wrapping instance share all inputs.
module tb_prog_fetch_unit;

  localparam int PC_W    = 3;
  localparam int INSTR_W = 8;

  logic clk;
  logic rst;
  logic start;
  logic halt_req;
  logic stall;
  logic [PC_W-1:0] pc_w, pc_nw;
  logic halted_w, halted_nw;
  logic [1:0] st_w, st_nw;

  int n_tests = 0;
  int n_fail  = 0;

  prog_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus_w ();
  prog_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus_nw ();

  assign bus_nw.out_ready  = bus_w.out_ready;
  assign bus_nw.br_valid   = bus_w.br_valid;
  assign bus_nw.br_rel     = bus_w.br_rel;
  assign bus_nw.br_target  = bus_w.br_target;
  assign bus_nw.prog_we    = bus_w.prog_we;
  assign bus_nw.prog_addr  = bus_w.prog_addr;
  assign bus_nw.prog_wdata = bus_w.prog_wdata;

  prog_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .pc(pc_w), .halted(halted_w), .fsm_state(st_w), .bus(bus_w.master)
  );

  prog_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .WRAP(1'b0)) dut_nw (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .pc(pc_nw), .halted(halted_nw), .fsm_state(st_nw), .bus(bus_nw.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst               = 1'b0;
    start             = 1'b0;
    halt_req          = 1'b0;
    stall             = 1'b0;
    bus_w.out_ready   = 1'b0;
    bus_w.br_valid    = 1'b0;
    bus_w.br_rel      = 1'b0;
    bus_w.br_target   = '0;
    bus_w.prog_we     = 1'b0;
    bus_w.prog_addr   = '0;
    bus_w.prog_wdata  = '0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic load_prog();
    for (int i = 0; i < 8; i++) begin
      bus_w.prog_we    = 1'b1;
      bus_w.prog_addr  = PC_W'(i);
      bus_w.prog_wdata = INSTR_W'(8'h10 + i);
      step();
    end
    bus_w.prog_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    reset_dut();
    check("rst_pc", 32'(pc_w), 32'h0);
    check("rst_out", 32'(bus_w.out), 32'h0);
    check("rst_valid", 32'(bus_w.out_valid), 32'h0);
    check("rst_halted", 32'(halted_w), 32'h0);
    check("rst_br_taken", 32'(bus_w.br_taken), 32'h0);
    check("rst_state", 32'(st_w), 32'h0);

    // 1/2: streaming with wrap, and halt on last address without wrap
    load_prog();
    bus_w.out_ready = 1'b1;
    start_run();
    check("t1_state_run", 32'(st_w), 32'h1);
    check("t1_pc_start", 32'(pc_w), 32'h0);
    for (int k = 0; k < 9; k++) begin
      step();
      check($sformatf("t1_out_%0d", k), 32'(bus_w.out), 32'(8'h10 + (k % 8)));
      check($sformatf("t1_valid_%0d", k), 32'(bus_w.out_valid), 32'h1);
      if (k == 7) begin
        check("t1_pc_wrap", 32'(pc_w), 32'h0);
        check("t2_nw_out", 32'(bus_nw.out), 32'h17);
        check("t2_nw_valid", 32'(bus_nw.out_valid), 32'h1);
        check("t2_nw_halted", 32'(halted_nw), 32'h1);
        check("t2_nw_pc", 32'(pc_nw), 32'h7);
      end
    end
    check("t2_nw_valid_drop", 32'(bus_nw.out_valid), 32'h0);
    check("t2_nw_halted_hold", 32'(halted_nw), 32'h1);
    check("t2_nw_pc_hold", 32'(pc_nw), 32'h7);

    // 3: backpressure on 8'h12, then stall
    reset_dut();
    load_prog();
    bus_w.out_ready = 1'b1;
    start_run();
    step();
    step();
    step();
    check("t3_out_12", 32'(bus_w.out), 32'h12);
    bus_w.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t3_bp_out_%0d", k), 32'(bus_w.out), 32'h12);
      check($sformatf("t3_bp_pc_%0d", k), 32'(pc_w), 32'h3);
      check($sformatf("t3_bp_valid_%0d", k), 32'(bus_w.out_valid), 32'h1);
    end
    bus_w.out_ready = 1'b1;
    step();
    check("t3_out_13", 32'(bus_w.out), 32'h13);
    check("t3_pc_4", 32'(pc_w), 32'h4);
    stall = 1'b1;
    step();
    check("t3_stall_valid", 32'(bus_w.out_valid), 32'h0);
    check("t3_stall_pc", 32'(pc_w), 32'h4);
    step();
    check("t3_stall_pc2", 32'(pc_w), 32'h4);
    stall = 1'b0;
    step();
    check("t3_out_14", 32'(bus_w.out), 32'h14);
    check("t3_valid_14", 32'(bus_w.out_valid), 32'h1);

    // 4: relative branch -2 from pc=2, then absolute branch to 5
    reset_dut();
    load_prog();
    bus_w.out_ready = 1'b1;
    start_run();
    step();
    step();
    check("t4_pc_2", 32'(pc_w), 32'h2);
    bus_w.br_valid  = 1'b1;
    bus_w.br_rel    = 1'b1;
    bus_w.br_target = 3'b110;
    #1;
    check("t4_br_taken", 32'(bus_w.br_taken), 32'h1);
    step();
    bus_w.br_valid = 1'b0;
    #1;
    check("t4_bubble", 32'(bus_w.out_valid), 32'h0);
    check("t4_pc_rel", 32'(pc_w), 32'h0);
    check("t4_br_taken_off", 32'(bus_w.br_taken), 32'h0);
    step();
    check("t4_out_after", 32'(bus_w.out), 32'h10);
    check("t4_valid_after", 32'(bus_w.out_valid), 32'h1);
    bus_w.br_valid  = 1'b1;
    bus_w.br_rel    = 1'b0;
    bus_w.br_target = 3'd5;
    step();
    bus_w.br_valid = 1'b0;
    check("t4_pc_abs", 32'(pc_w), 32'h5);
    step();
    check("t4_out_abs", 32'(bus_w.out), 32'h15);

    // 5: halt at pc=4, patch mem[4], resume; writes in RUN are ignored
    reset_dut();
    load_prog();
    bus_w.out_ready = 1'b1;
    start_run();
    repeat (4) step();
    check("t5_pc_4", 32'(pc_w), 32'h4);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("t5_halted", 32'(halted_w), 32'h1);
    check("t5_pc_hold", 32'(pc_w), 32'h4);
    check("t5_valid_drop", 32'(bus_w.out_valid), 32'h0);
    bus_w.prog_we    = 1'b1;
    bus_w.prog_addr  = 3'd4;
    bus_w.prog_wdata = 8'hAA;
    step();
    bus_w.prog_we = 1'b0;
    start_run();
    check("t5_resume_state", 32'(st_w), 32'h1);
    bus_w.prog_we    = 1'b1;
    bus_w.prog_addr  = 3'd6;
    bus_w.prog_wdata = 8'h55;
    step();
    bus_w.prog_we = 1'b0;
    check("t5_out_aa", 32'(bus_w.out), 32'hAA);
    step();
    check("t5_out_15", 32'(bus_w.out), 32'h15);
    step();
    check("t5_run_write_ignored", 32'(bus_w.out), 32'h16);

    // 6: asynchronous reset between edges
    reset_dut();
    load_prog();
    bus_w.out_ready = 1'b1;
    start_run();
    step();
    step();
    check("t6_pre_out", 32'(bus_w.out), 32'h11);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus_w.out_valid), 32'h0);
    check("t6_async_pc", 32'(pc_w), 32'h0);
    check("t6_async_state", 32'(st_w), 32'h0);
    #2;
    rst = 1'b1;
    step();
    step();
    check("t6_idle_state", 32'(st_w), 32'h0);
    check("t6_idle_valid", 32'(bus_w.out_valid), 32'h0);
    check("t6_idle_pc", 32'(pc_w), 32'h0);
    start_run();
    step();
    check("t6_restart_out", 32'(bus_w.out), 32'h10);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
